// File: rtl/message_loader.sv
// message_loader: packs a byte stream big-endian into 32-bit words, writes
// them to the message memory, then starts the hash generator and waits for it.
// Optional feature: define LOADER_COUNT_EN to add the 8-bit msgCount output
// (completed hash handshakes, wrapping).
module message_loader #(
    parameter int unsigned WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic [3:0]  memAddr,
    output logic [31:0] memDataOut,
    output logic        memWrite,
    output logic        memSel,
    output logic        hashStart,
    input  logic        hashDone
`ifdef LOADER_COUNT_EN
    ,
    output logic [7:0]  msgCount
`endif
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_FIRE,
        S_WAIT
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

    state_t      r_state;
    logic [1:0]  r_byteCnt;
    logic [3:0]  r_wordIdx;
    logic [23:0] r_pack;
    // Set once the last word of the message has been captured; holds off
    // further bytes during that word's write cycle so none is dropped on
    // the way into FIRE.
    logic        r_full;

    logic        w_accept;
    logic        w_lastByte;

    // Handshake and port-ownership decode from the registered state.
    assign byteReady  = (r_state == S_LOAD) && !r_full;
    assign memSel     = (r_state != S_WAIT);
    assign w_accept   = byteValid && byteReady;
    assign w_lastByte = (r_byteCnt == 2'd3);

    // Loader state machine: byte packing, word writes and hash handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_byteCnt  <= '0;
            r_wordIdx  <= '0;
            r_pack     <= '0;
            r_full     <= 1'b0;
            memAddr    <= '0;
            memDataOut <= '0;
            memWrite   <= 1'b0;
            hashStart  <= 1'b0;
        end else begin
            memWrite  <= 1'b0;
            hashStart <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_pack    <= {r_pack[15:0], byteIn};
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (w_lastByte) begin
                            memWrite   <= 1'b1;
                            memAddr    <= r_wordIdx;
                            memDataOut <= {r_pack, byteIn};
                            if (r_wordIdx == LAST_WORD) begin
                                r_full <= 1'b1;
                            end else begin
                                r_wordIdx <= r_wordIdx + 4'd1;
                            end
                        end
                    end
                    // Leave for FIRE once the final word's write cycle is done.
                    if (memWrite && r_full) begin
                        r_state   <= S_FIRE;
                        hashStart <= 1'b1;
                    end
                end
                S_FIRE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (hashDone) begin
                        r_state   <= S_LOAD;
                        r_full    <= 1'b0;
                        r_wordIdx <= '0;
                        r_byteCnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

`ifdef LOADER_COUNT_EN
    // Completed-message counter, bumped on each WAIT-to-LOAD handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msgCount <= '0;
        end else if (r_state == S_WAIT && hashDone) begin
            msgCount <= msgCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_message_loader.sv
// Testbench for message_loader: a 16-word instance for streaming, gap, WAIT
// and reset behaviour, and a 1-word instance for the short-message case and
// the optional message counter (LOADER_COUNT_EN).
module tb_message_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-word instance
    logic [7:0]  byteIn = '0;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic [3:0]  memAddr;
    logic [31:0] memDataOut;
    logic        memWrite;
    logic        memSel;
    logic        hashStart;
    logic        hashDone = 1'b0;

    // 1-word instance
    logic [7:0]  b1_in = '0;
    logic        b1_valid = 1'b0;
    logic        b1_ready;
    logic [3:0]  b1_addr;
    logic [31:0] b1_data;
    logic        b1_write;
    logic        b1_sel;
    logic        b1_start;
    logic        b1_done = 1'b0;
`ifdef LOADER_COUNT_EN
    logic [7:0]  msgCount;
    logic [7:0]  b1_count;
`endif

    message_loader #(.WORDS(16)) dut (
        .clk(clk), .rst(rst), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(byteReady), .memAddr(memAddr), .memDataOut(memDataOut),
        .memWrite(memWrite), .memSel(memSel), .hashStart(hashStart),
        .hashDone(hashDone)
`ifdef LOADER_COUNT_EN
        , .msgCount(msgCount)
`endif
    );

    message_loader #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .byteIn(b1_in), .byteValid(b1_valid),
        .byteReady(b1_ready), .memAddr(b1_addr), .memDataOut(b1_data),
        .memWrite(b1_write), .memSel(b1_sel), .hashStart(b1_start),
        .hashDone(b1_done)
`ifdef LOADER_COUNT_EN
        , .msgCount(b1_count)
`endif
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and observation queues
    int cyc = 0;
    always @(posedge clk) cyc++;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          hs_cyc[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  sent_q[$];
    int          w1_addr[$];
    logic [31:0] w1_data[$];
    int          w1_cyc[$];
    int          h1_cyc[$];

    logic [3:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    // Monitor on the falling edge: collect writes/pulses, check held outputs.
    always @(negedge clk) begin
        if (rst) begin
            last_addr = '0;
            last_data = '0;
        end else begin
            if (memWrite) begin
                wr_addr.push_back(int'(memAddr));
                wr_data.push_back(memDataOut);
                wr_cyc.push_back(cyc);
                last_addr = memAddr;
                last_data = memDataOut;
            end else begin
                check("hold_addr", 32'(memAddr), 32'(last_addr));
                check("hold_data", memDataOut, last_data);
            end
            if (hashStart) hs_cyc.push_back(cyc);
            if (byteValid && byteReady) acc_q.push_back(byteIn);
            if (b1_write) begin
                w1_addr.push_back(int'(b1_addr));
                w1_data.push_back(b1_data);
                w1_cyc.push_back(cyc);
            end
            if (b1_start) h1_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        hs_cyc.delete(); acc_q.delete(); sent_q.delete();
        w1_addr.delete(); w1_data.delete(); w1_cyc.delete(); h1_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byteIn = b;
        byteValid = 1'b1;
        while (byteReady !== 1'b1) begin
            if (n == 100) begin
                check("ready_timeout", 32'(byteReady), 32'd1);
                byteValid = 1'b0;
                return;
            end
            tick();
            n++;
        end
        tick();
    endtask

    // Message of nbytes; counting or random data; optional forced gap
    // before byte gap_at and optional random gaps.
    task automatic send_msg(input int nbytes, input bit rnd, input int gap_at, input bit rnd_gaps);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = rnd ? 8'($urandom) : i[7:0];
            if (i == gap_at || (rnd_gaps && $urandom_range(0, 3) == 0)) begin
                byteValid = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
            sent_q.push_back(b);
            send_byte(b);
        end
        byteValid = 1'b0;
    endtask

    task automatic wait_hs();
        int n = 0;
        while (hs_cyc.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        if (hs_cyc.size() == 0) check("hashStart_timeout", 32'd0, 32'd1);
    endtask

    // Compare collected writes against words built from the sent bytes.
    task automatic check_msg(input string tag, input int nwords);
        logic [31:0] exp;
        int last;
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(nwords));
        for (int k = 0; k < nwords && k < wr_addr.size(); k++) begin
            exp = {sent_q[4*k], sent_q[4*k+1], sent_q[4*k+2], sent_q[4*k+3]};
            check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
            check($sformatf("%s_data%0d", tag, k), wr_data[k], exp);
        end
        check({tag, "_nstart"}, 32'(hs_cyc.size()), 32'd1);
        if (hs_cyc.size() > 0 && wr_cyc.size() > 0) begin
            last = wr_cyc[wr_cyc.size()-1];
            check({tag, "_start_lat"}, 32'(hs_cyc[0] - last), 32'd1);
        end
    endtask

    task automatic finish_hash(input string tag);
        tick();
        tick();
        check({tag, "_wait_ready"}, 32'(byteReady), 32'd0);
        check({tag, "_wait_sel"}, 32'(memSel), 32'd0);
        hashDone = 1'b1;
        tick();
        hashDone = 1'b0;
        check({tag, "_reload_ready"}, 32'(byteReady), 32'd1);
        check({tag, "_reload_sel"}, 32'(memSel), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byteReady), 32'd1);
        check({tag, "_sel"}, 32'(memSel), 32'd1);
        check({tag, "_write"}, 32'(memWrite), 32'd0);
        check({tag, "_start"}, 32'(hashStart), 32'd0);
        check({tag, "_addr"}, 32'(memAddr), 32'd0);
        check({tag, "_data"}, memDataOut, 32'd0);
    endtask

    task automatic send1_msg(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] w;
        int n;
        w = {b0, b1, b2, b3};
        for (int i = 3; i >= 0; i--) begin
            b1_in = w[8*i +: 8];
            b1_valid = 1'b1;
            n = 0;
            while (b1_ready !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            if (n == 100) check("w1_ready_timeout", 32'(b1_ready), 32'd1);
            tick();
        end
        b1_valid = 1'b0;
        n = 0;
        while (h1_cyc.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        if (h1_cyc.size() == 0) check("w1_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic done1();
        tick();
        b1_done = 1'b1;
        tick();
        b1_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nw;
        int na;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        tick();

        // hashDone in LOAD is ignored
        hashDone = 1'b1;
        tick();
        hashDone = 1'b0;
        check("hd_load_ready", 32'(byteReady), 32'd1);
        check("hd_load_start", 32'(hs_cyc.size()), 32'd0);

        // Counting stream at full line rate
        clear_q();
        t0 = cyc;
        send_msg(64, 1'b0, -1, 1'b0);
        check("line_rate_cycles", 32'(cyc - t0), 32'd64);
        wait_hs();
        check_msg("seq", 16);
        tick();
        check("seq_wait_ready", 32'(byteReady), 32'd0);
        check("seq_wait_sel", 32'(memSel), 32'd0);
        check("seq_wait_start", 32'(hashStart), 32'd0);

        // Bytes offered in WAIT are ignored; hashDone re-enters LOAD
        nw = wr_addr.size();
        na = acc_q.size();
        byteIn = 8'hAA;
        byteValid = 1'b1;
        repeat (10) tick();
        byteValid = 1'b0;
        hashDone = 1'b1;
        tick();
        hashDone = 1'b0;
        check("wait_no_write", 32'(wr_addr.size()), 32'(nw));
        check("wait_no_accept", 32'(acc_q.size()), 32'(na));
        check("wait_no_restart", 32'(hs_cyc.size()), 32'd1);
        check("reload_ready", 32'(byteReady), 32'd1);
        check("reload_sel", 32'(memSel), 32'd1);

        // Gap inside word 5
        clear_q();
        send_msg(64, 1'b0, 22, 1'b0);
        wait_hs();
        check_msg("gap", 16);
        finish_hash("gap");

        // Random data with random gaps
        for (int m = 0; m < 2; m++) begin
            clear_q();
            send_msg(64, 1'b1, -1, 1'b1);
            wait_hs();
            check_msg($sformatf("rnd%0d", m), 16);
            finish_hash($sformatf("rnd%0d", m));
        end

        // Reset mid-message, asynchronous
        clear_q();
        send_msg(22, 1'b1, -1, 1'b0);
        check("mid_addr_before", 32'(memAddr), 32'd4);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        tick();
        rst = 1'b0;
        tick();
        clear_q();
        send_msg(64, 1'b1, -1, 1'b0);
        wait_hs();
        check_msg("post_rst", 16);

        // Reset in WAIT abandons the hash; next message starts fresh
        tick();
        rst = 1'b1;
        #1 check_reset_outputs("rst_wait");
        tick();
        rst = 1'b0;
        clear_q();
        send_msg(64, 1'b1, -1, 1'b1);
        wait_hs();
        check_msg("after_wait_rst", 16);
        finish_hash("after_wait_rst");

        // Single-word message
        clear_q();
        send1_msg(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        check("w1_nwrites", 32'(w1_addr.size()), 32'd1);
        if (w1_addr.size() > 0) begin
            check("w1_addr", 32'(w1_addr[0]), 32'd0);
            check("w1_data", w1_data[0], 32'hDEADBEEF);
            if (h1_cyc.size() > 0) check("w1_start_lat", 32'(h1_cyc[0] - w1_cyc[0]), 32'd1);
        end
        tick();
        check("w1_wait_ready", 32'(b1_ready), 32'd0);
        check("w1_wait_sel", 32'(b1_sel), 32'd0);
        check("w1_nstart", 32'(h1_cyc.size()), 32'd1);
        done1();
        check("w1_reload_ready", 32'(b1_ready), 32'd1);

`ifdef LOADER_COUNT_EN
        check("cnt_one", 32'(b1_count), 32'd1);
        // 256 more messages: 257 total wraps the counter back to 1
        for (int m = 0; m < 256; m++) begin
            clear_q();
            send1_msg(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            done1();
            if (m == 254) check("cnt_wrap0", 32'(b1_count), 32'd0);
        end
        check("cnt_257", 32'(b1_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/message_loader.md
MESSAGE_LOADER -- requirements
Module: message_loader

Interface
REQ-001 Parameter: WORDS, default 16, number of 32-bit words per message, legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 byteIn  input  8  message byte from the upstream source.
REQ-005 byteValid  input  1  byteIn holds a valid byte.
REQ-006 byteReady  output  1  loader accepts byteIn this cycle; a byte transfers when byteValid=1 and byteReady=1 at a rising edge.
REQ-007 memAddr  output  4  message memory word address.
REQ-008 memDataOut  output  32  word written to message memory.
REQ-009 memWrite  output  1  memory write strobe; write occurs at the rising edge where memWrite=1.
REQ-010 memSel  output  1  1 = loader owns the memory port; 0 = hash generator owns it.
REQ-011 hashStart  output  1  one-cycle start pulse to the hash generator.
REQ-012 hashDone  input  1  hash generator dataOutValid.

Function
REQ-013 States: LOAD, FIRE, WAIT.
REQ-014 LOAD: byteReady=1, memSel=1, hashStart=0.
REQ-015 Packing: the first byte of each group of 4 goes to [31:24], then [23:16], [15:8], [7:0] (big-endian).
REQ-016 Accepting the 4th byte of a word: the cycle after, memWrite=1 for exactly one cycle, memDataOut = packed word, memAddr = word index; the word index then increments.
REQ-017 Byte acceptance continues during the write cycle without stall; no byte is lost or duplicated at full line rate.
REQ-018 memWrite=0 outside write cycles; memAddr and memDataOut hold their last value then.
REQ-019 Transition to FIRE: the cycle after the write of word index WORDS-1.
REQ-020 FIRE lasts one cycle: hashStart=1, byteReady=0, memSel=1.
REQ-021 FIRE always goes to WAIT.
REQ-022 WAIT: byteReady=0, memSel=0, hashStart=0.
REQ-023 WAIT to LOAD: on the edge where hashDone=1; the word index and byte counter are zero on re-entry.
REQ-024 hashDone in LOAD or FIRE is ignored.
REQ-025 byteValid while byteReady=0 is ignored; the byte is not consumed.
REQ-026 Word index counts 0..WORDS-1 and never wraps inside a message.
REQ-027 A partial word (fewer than 4 bytes) is never written.

Reset
REQ-028 rst=1 asynchronously forces: state LOAD, byte counter 0, word index 0, packing register 0, memAddr=0, memDataOut=0, memWrite=0, hashStart=0.
REQ-029 During and after reset, outputs follow LOAD: byteReady=1, memSel=1.
REQ-030 Reset mid-message discards all collected bytes; reset in WAIT abandons the pending hash.

Configuration
REQ-031 Macro LOADER_COUNT_EN defined: adds output msgCount (8 bits), reset to 0, incremented on each WAIT-to-LOAD transition, wrapping 255 to 0.
REQ-032 Macro LOADER_COUNT_EN undefined: msgCount port and its counter are absent; all other behaviour is identical.

Verification
REQ-033 Stream 64 bytes 0x00..0x3F with byteValid held 1 -> 16 writes: addr 0 = 0x00010203 ... addr 15 = 0x3C3D3E3F, each one cycle; hashStart pulses one cycle after the last write; byteReady=0 afterwards.
REQ-034 In WAIT, drive byteValid=1 with 0xAA for 10 cycles, then hashDone=1 for one cycle -> no write and no byte consumed; LOAD is entered the next cycle with memSel=1 and the next write at addr 0.
REQ-035 Insert a random byteValid gap between bytes 2 and 3 of word 5 -> addr 5 data unchanged from REQ-033; still exactly 16 writes.
REQ-036 Assert rst after 22 bytes -> all outputs at reset values immediately; a fresh 64-byte stream produces writes starting at addr 0 with correct data.
REQ-037 WORDS=1, bytes 0xDE 0xAD 0xBE 0xEF -> one write 0xDEADBEEF at addr 0, followed next cycle by hashStart.
REQ-038 With LOADER_COUNT_EN, run 257 messages -> msgCount=1; without LOADER_COUNT_EN, the design compiles and the port is absent.
